// File: rtl/uart_wb_master.sv
// Bridges a UART byte stream to a pipelined Wishbone initiator.
// Each command frame (read or write) runs one 32-bit bus transaction and produces one response frame.
module uart_wb_master #(
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] RSP_READ  = 8'h81;
  localparam logic [7:0] RSP_WRITE = 8'h82;
  localparam logic [7:0] RSP_BERR  = 8'hEE;
  localparam logic [7:0] RSP_BTMO  = 8'hED;
  localparam logic [7:0] RSP_BADOP = 8'hEF;

  state_t      state, state_next;
  logic        armed;
  logic [1:0]  fld_cnt;
  logic [2:0]  byte_cnt;
  logic [31:0] rd_data;
  logic [31:0] idle_cnt;
  logic [31:0] tmo_cnt;

  logic rx_fire, tx_fire, op_known, fld_last, rx_tmo;
  logic bus_ack, bus_err, bus_tmo;

  assign wb_sel_o = 4'hF;
  assign rx_fire  = rx_valid_i & rx_ready_o;
  assign tx_fire  = tx_valid_o & tx_ready_i;
  assign op_known = (rx_data_i == OP_READ) || (rx_data_i == OP_WRITE);
  assign fld_last = (fld_cnt == 2'd3);
  assign rx_tmo   = (RX_TIMEOUT != 0) && !rx_fire && (idle_cnt == RX_TIMEOUT - 1);
  // ack wins over err, and either wins over a timeout landing on the same edge.
  assign bus_ack  = wb_cyc_o & wb_ack_i;
  assign bus_err  = wb_cyc_o & wb_err_i & ~wb_ack_i;
  assign bus_tmo  = wb_cyc_o & ~wb_ack_i & ~wb_err_i & (tmo_cnt == BUS_TIMEOUT - 1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (rx_fire) state_next = op_known ? ADDR : RESP;
      ADDR: begin
        if (rx_fire && fld_last) state_next = wb_we_o ? DATA : BUS;
        else if (rx_tmo)         state_next = IDLE;
      end
      DATA: begin
        if (rx_fire && fld_last) state_next = BUS;
        else if (rx_tmo)         state_next = IDLE;
      end
      BUS:  if (bus_ack || bus_err || bus_tmo) state_next = RESP;
      RESP: if (tx_fire && byte_cnt == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rx stays closed until the first edge after reset release.
  always_comb begin
    rx_ready_o = 1'b0;
    if (armed && (state == IDLE || state == ADDR || state == DATA)) rx_ready_o = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      fld_cnt    <= '0;
      byte_cnt   <= '0;
      rd_data    <= '0;
      idle_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: if (rx_fire) begin
          wb_we_o  <= (rx_data_i == OP_WRITE);
          fld_cnt  <= '0;
          idle_cnt <= '0;
          if (!op_known) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= RSP_BADOP;
            byte_cnt   <= '0;
          end
        end
        ADDR, DATA: begin
          if (rx_fire) begin
            if (state == ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_data_i};
            else               wb_dat_o <= {wb_dat_o[23:0], rx_data_i};
            fld_cnt  <= fld_cnt + 2'd1;
            idle_cnt <= '0;
            // Launch the bus cycle on the same edge that takes the last command byte.
            if (fld_last && (state == DATA || !wb_we_o)) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              tmo_cnt  <= '0;
            end
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        BUS: begin
          if (wb_stb_o && !wb_stall_i) wb_stb_o <= 1'b0;
          tmo_cnt <= tmo_cnt + 32'd1;
          if (bus_ack || bus_err || bus_tmo) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            tx_valid_o <= 1'b1;
            byte_cnt   <= '0;
            if (bus_ack && wb_we_o) tx_data_o <= RSP_WRITE;
            else if (bus_ack) begin
              tx_data_o <= RSP_READ;
              rd_data   <= wb_dat_i;
              byte_cnt  <= 3'd4;
            end
            else if (bus_err) tx_data_o <= RSP_BERR;
            else              tx_data_o <= RSP_BTMO;
          end
        end
        RESP: if (tx_fire) begin
          if (byte_cnt == 3'd0) tx_valid_o <= 1'b0;
          else begin
            tx_data_o <= rd_data[31:24];
            rd_data   <= {rd_data[23:0], 8'h00};
            byte_cnt  <= byte_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: drives frames on rx, plays the Wishbone slave by hand,
// and checks bus activity and response bytes against hand-computed values.
module tb_uart_wb_master;

  localparam int unsigned BUS_TO = 16;
  localparam int unsigned RX_TO  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_wb_master #(.BUS_TIMEOUT(BUS_TO), .RX_TIMEOUT(RX_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All helpers start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 100) begin @(negedge clk); n++; end
    chk("rx_accept", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h01);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp, input bit hold);
    int n = 0;
    while (!tx_valid_o && n < 100) begin @(negedge clk); n++; end
    chk(tag, {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, exp});
    if (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, exp});
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit cyc_seen;

    // Reset state
    #2;
    chk("rst_cyc",   {31'd0, wb_cyc_o},   32'd0);
    chk("rst_stb",   {31'd0, wb_stb_o},   32'd0);
    chk("rst_we",    {31'd0, wb_we_o},    32'd0);
    chk("rst_adr",   wb_adr_o,            32'd0);
    chk("rst_dat",   wb_dat_o,            32'd0);
    chk("rst_txv",   {31'd0, tx_valid_o}, 32'd0);
    chk("rst_txd",   {24'd0, tx_data_o},  32'd0);
    chk("rst_rdy",   {31'd0, rx_ready_o}, 32'd0);
    chk("rst_sel",   {28'd0, wb_sel_o},   32'hF);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, rx_ready_o}, 32'd1);

    // Write 0xDEADBEEF to 0x00001004, ack two cycles after stb is taken
    send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("w_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("w_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("w_we",  {31'd0, wb_we_o},  32'd1);
    chk("w_adr", wb_adr_o, 32'h0000_1004);
    chk("w_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("w_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("w_rdy_busy", {31'd0, rx_ready_o}, 32'd0);
    @(negedge clk);
    chk("w_stb_drop", {31'd0, wb_stb_o}, 32'd0);
    chk("w_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk); wb_ack_i = 1'b1;
    @(negedge clk); wb_ack_i = 1'b0;
    chk("w_cyc_end", {31'd0, wb_cyc_o}, 32'd0);
    chk("w_txv_lat", {31'd0, tx_valid_o}, 32'd1);
    recv_byte("w_rsp", 8'h82, 1'b0);
    chk("w_txv_done", {31'd0, tx_valid_o}, 32'd0);
    chk("w_rdy_idle", {31'd0, rx_ready_o}, 32'd1);

    // Read 0x00002000 with stall held for three cycles, tx_ready toggling
    wb_stall_i = 1'b1;
    send_read(32'h0000_2000);
    chk("r_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("r_we",  {31'd0, wb_we_o},  32'd0);
    chk("r_adr", wb_adr_o, 32'h0000_2000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r_stb_stalled", {31'd0, wb_stb_o}, 32'd1);
    end
    wb_stall_i = 1'b0;
    @(negedge clk);
    chk("r_stb_drop", {31'd0, wb_stb_o}, 32'd0);
    chk("r_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    @(negedge clk); wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("r_cyc_end", {31'd0, wb_cyc_o}, 32'd0);
    recv_byte("r_b0", 8'h81, 1'b1);
    recv_byte("r_b1", 8'h12, 1'b1);
    recv_byte("r_b2", 8'h34, 1'b1);
    recv_byte("r_b3", 8'h56, 1'b1);
    recv_byte("r_b4", 8'h78, 1'b1);
    chk("r_txv_done", {31'd0, tx_valid_o}, 32'd0);

    // Stray ack with no cycle open must not produce anything
    wb_ack_i = 1'b1;
    @(negedge clk); wb_ack_i = 1'b0;
    @(negedge clk);
    chk("stray_ack_txv", {31'd0, tx_valid_o}, 32'd0);

    // Read answered by err
    send_read(32'h0000_0040);
    chk("e_cyc", {31'd0, wb_cyc_o}, 32'd1);
    wb_err_i = 1'b1;
    @(negedge clk); wb_err_i = 1'b0;
    chk("e_cyc_end", {31'd0, wb_cyc_o}, 32'd0);
    chk("e_stb_end", {31'd0, wb_stb_o}, 32'd0);
    recv_byte("e_rsp", 8'hEE, 1'b0);
    chk("e_txv_done", {31'd0, tx_valid_o}, 32'd0);

    // Read never answered: cyc must stay high exactly BUS_TO cycles
    send_read(32'h0000_0050);
    n = 0;
    while (wb_cyc_o && n < 40) begin n++; @(negedge clk); end
    chk("t_cyc_len", n, BUS_TO);
    chk("t_stb_end", {31'd0, wb_stb_o}, 32'd0);
    recv_byte("t_rsp", 8'hED, 1'b0);

    // Unknown opcode, then an abandoned partial write frame
    send_byte(8'h55);
    recv_byte("op_rsp", 8'hEF, 1'b0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    cyc_seen = 1'b0;
    repeat (RX_TO + 5) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_seen = 1'b1;
    end
    chk("p_no_cyc", {31'd0, cyc_seen}, 32'd0);
    chk("p_rdy", {31'd0, rx_ready_o}, 32'd1);
    send_read(32'h0000_3000);
    chk("p_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("p_we",  {31'd0, wb_we_o},  32'd0);
    chk("p_adr", wb_adr_o, 32'h0000_3000);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk); wb_ack_i = 1'b0; wb_dat_i = '0;
    recv_byte("p_b0", 8'h81, 1'b0);
    recv_byte("p_b1", 8'hCA, 1'b0);
    recv_byte("p_b2", 8'hFE, 1'b0);
    recv_byte("p_b3", 8'hF0, 1'b0);
    recv_byte("p_b4", 8'h0D, 1'b0);

    // Reset in the middle of a bus cycle
    send_read(32'h0000_0060);
    chk("x_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("x_cyc_async", {31'd0, wb_cyc_o},   32'd0);
    chk("x_stb_async", {31'd0, wb_stb_o},   32'd0);
    chk("x_txv_async", {31'd0, tx_valid_o}, 32'd0);
    chk("x_rdy_async", {31'd0, rx_ready_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("x_rdy_idle", {31'd0, rx_ready_o}, 32'd1);
    chk("x_adr_clr",  wb_adr_o, 32'd0);
    chk("x_txv_idle", {31'd0, tx_valid_o}, 32'd0);
    send_read(32'h0000_0070);
    chk("x2_adr", wb_adr_o, 32'h0000_0070);
    wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0001;
    @(negedge clk); wb_ack_i = 1'b0; wb_dat_i = '0;
    recv_byte("x2_b0", 8'h81, 1'b0);
    recv_byte("x2_b1", 8'hA5, 1'b0);
    recv_byte("x2_b2", 8'hA5, 1'b0);
    recv_byte("x2_b3", 8'h00, 1'b0);
    recv_byte("x2_b4", 8'h01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
